// File: rtl/ex_fwd_scoreboard.sv
// rtl/ex_fwd_scoreboard.sv - EX-stage operand forwarding unit with load-use hazard tracking
//
// Owns the ID/EX operand register and a DEPTH-entry history of older in-flight
// instructions (Q[1]=MEM, Q[2]=WB, Q[3]=post-WB, ...). For each source operand
// it picks the youngest matching producer result. It also raises a stall when
// an instruction in ID depends on a load whose data is not yet available.
//
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   id_valid       ID holds an instruction to issue
//   id_rd, id_wen  destination register and its write enable
//   id_load        instruction in ID is a load
//   id_src_addr    NUM_SRC packed source register addresses
//   id_rf_data     NUM_SRC packed register-file read values
//   flush          kill the instruction entering EX
//   stage_result   DEPTH packed results, stage k at slot k-1
//   stall          ID must hold; EX receives a bubble
//   ex_valid       EX register holds a live instruction
//   ex_operand     NUM_SRC packed forwarded operands
//   ex_fwd_sel     NUM_SRC packed 8-bit selects: 0 = captured value, k = stage k
//   stall_cnt      saturating count of stall cycles
module ex_fwd_scoreboard #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_SRC  = 2,
   parameter int DEPTH    = 3,
   parameter int LOAD_LAT = 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        id_valid,
   input  logic [ADDR_W-1:0]           id_rd,
   input  logic                        id_wen,
   input  logic                        id_load,
   input  logic [NUM_SRC*ADDR_W-1:0]   id_src_addr,
   input  logic [NUM_SRC*DATA_W-1:0]   id_rf_data,
   input  logic                        flush,
   input  logic [DEPTH*DATA_W-1:0]     stage_result,
   output logic                        stall,
   output logic                        ex_valid,
   output logic [NUM_SRC*DATA_W-1:0]   ex_operand,
   output logic [NUM_SRC*8-1:0]        ex_fwd_sel,
   output logic [15:0]                 stall_cnt
);

   // EX register
   logic              ex_valid_q;
   logic [ADDR_W-1:0] ex_rd;
   logic              ex_wen;
   logic              ex_load;
   logic [ADDR_W-1:0] ex_src [NUM_SRC];
   logic [DATA_W-1:0] ex_val [NUM_SRC];

   // Older in-flight instructions, index = stages past EX
   logic              q_valid [1:DEPTH];
   logic [ADDR_W-1:0] q_rd    [1:DEPTH];
   logic              q_wen   [1:DEPTH];
   logic              q_load  [1:DEPTH];

   logic              load_hit;
   logic              capture;
   logic [DATA_W-1:0] cap_val [NUM_SRC];

   // Register 0 is hard-wired zero, so a producer targeting it never matches.
   function automatic logic match(input logic v, input logic w,
                                  input logic [ADDR_W-1:0] rd,
                                  input logic [ADDR_W-1:0] a);
      return v && w && (rd == a) && (a != '0);
   endfunction

   assign ex_valid = ex_valid_q;

   // Scan oldest to youngest so the youngest matching producer is the last write.
   always_comb begin
      ex_operand = '0;
      ex_fwd_sel = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         ex_operand[i*DATA_W +: DATA_W] = ex_val[i];
         for (int k = DEPTH; k >= 1; k--) begin
            if (match(q_valid[k], q_wen[k], q_rd[k], ex_src[i])) begin
               ex_operand[i*DATA_W +: DATA_W] = stage_result[(k-1)*DATA_W +: DATA_W];
               ex_fwd_sel[i*8 +: 8]           = 8'(k);
            end
         end
      end
   end

   // A load in EX or in any stage before its data appears blocks a dependent issue.
   always_comb begin
      load_hit = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (ex_load && match(ex_valid_q, ex_wen, ex_rd, id_src_addr[i*ADDR_W +: ADDR_W]))
            load_hit = 1'b1;
         for (int k = 1; k < LOAD_LAT; k++) begin
            if (q_load[k] && match(q_valid[k], q_wen[k], q_rd[k], id_src_addr[i*ADDR_W +: ADDR_W]))
               load_hit = 1'b1;
         end
      end
   end

   assign stall   = id_valid && !flush && load_hit;
   assign capture = id_valid && !flush && !load_hit;

   // The oldest tracked stage writes the RF on the same edge the ID read is
   // captured, so its result is folded into the captured value here.
   always_comb begin
      for (int i = 0; i < NUM_SRC; i++) begin
         cap_val[i] = id_rf_data[i*DATA_W +: DATA_W];
         if (match(q_valid[DEPTH], q_wen[DEPTH], q_rd[DEPTH], id_src_addr[i*ADDR_W +: ADDR_W]))
            cap_val[i] = stage_result[(DEPTH-1)*DATA_W +: DATA_W];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid_q <= 1'b0;
         ex_rd      <= '0;
         ex_wen     <= 1'b0;
         ex_load    <= 1'b0;
         for (int i = 0; i < NUM_SRC; i++) begin
            ex_src[i] <= '0;
            ex_val[i] <= '0;
         end
         for (int k = 1; k <= DEPTH; k++) begin
            q_valid[k] <= 1'b0;
            q_rd[k]    <= '0;
            q_wen[k]   <= 1'b0;
            q_load[k]  <= 1'b0;
         end
         stall_cnt <= '0;
      end else begin
         for (int k = DEPTH; k >= 2; k--) begin
            q_valid[k] <= q_valid[k-1];
            q_rd[k]    <= q_rd[k-1];
            q_wen[k]   <= q_wen[k-1];
            q_load[k]  <= q_load[k-1];
         end
         q_valid[1] <= ex_valid_q;
         q_rd[1]    <= ex_rd;
         q_wen[1]   <= ex_wen;
         q_load[1]  <= ex_load;

         ex_valid_q <= capture;
         if (capture) begin
            ex_rd   <= id_rd;
            ex_wen  <= id_wen;
            ex_load <= id_load;
            for (int i = 0; i < NUM_SRC; i++) begin
               ex_src[i] <= id_src_addr[i*ADDR_W +: ADDR_W];
               ex_val[i] <= cap_val[i];
            end
         end

         if (stall && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
      end
   end

endmodule
